// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops in 2 edges; iterative MUL/MULH/DIV/REM in WIDTH+2 edges.
// No queuing: start is only sampled in IDLE and ignored while busy; Alures/flags hold until the next done.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             i,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       af,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Alures,
    output logic             Zero,
    output logic             Neg,
    output logic             ovfalu
);

    localparam logic [3:0] AF_AND  = 4'b0000;
    localparam logic [3:0] AF_OR   = 4'b0001;
    localparam logic [3:0] AF_ADD  = 4'b0010;
    localparam logic [3:0] AF_SUB  = 4'b0011;
    localparam logic [3:0] AF_XOR  = 4'b0100;
    localparam logic [3:0] AF_NOR  = 4'b0101;
    localparam logic [3:0] AF_SLT  = 4'b0110;
    localparam logic [3:0] AF_SLTU = 4'b0111;
    localparam logic [3:0] AF_SLL  = 4'b1000;
    localparam logic [3:0] AF_SRL  = 4'b1001;
    localparam logic [3:0] AF_MUL  = 4'b1010;
    localparam logic [3:0] AF_MULH = 4'b1011;
    localparam logic [3:0] AF_DIV  = 4'b1100;
    localparam logic [3:0] AF_REM  = 4'b1101;
    localparam logic [3:0] AF_SRA  = 4'b1110;

    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, res_q;
    logic [3:0]       af_q;
    logic             i_q, busy_q, done_q, ovf_q;
    logic [SHW-1:0]   cnt_q;

    // Operand magnitudes at issue time seed the iterative datapath.
    logic             in_multi, in_div;
    logic [WIDTH-1:0] in_a_mag, in_b_mag;
    always_comb begin
        in_multi = af inside {AF_MUL, AF_MULH, AF_DIV, AF_REM};
        in_div   = (af == AF_DIV) || (af == AF_REM);
        in_a_mag = (i && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        in_b_mag = (i && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    end

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = i_q & a_q[WIDTH-1];
    assign b_neg = i_q & b_q[WIDTH-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;

    // One iteration: MUL shifts {hi,lo} right with a conditional add of |A|;
    // DIV shifts the dividend out of lo into hi and keeps the trial subtract when it fits.
    logic [WIDTH:0]   madd, dshift, dtrial;
    logic [WIDTH-1:0] hi_d, lo_d;
    always_comb begin
        madd   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_mag : {WIDTH{1'b0}})};
        dshift = {hi_q, lo_q[WIDTH-1]};
        dtrial = dshift - {1'b0, b_mag};
        hi_d   = madd[WIDTH:1];
        lo_d   = {madd[0], lo_q[WIDTH-1:1]};
        if ((af_q == AF_DIV) || (af_q == AF_REM)) begin
            hi_d = dtrial[WIDTH] ? dshift[WIDTH-1:0] : dtrial[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~dtrial[WIDTH]};
        end
    end

    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo, rem, sum, diff, res_d;
    logic [SHW-1:0]     sh;
    logic               ovf_d, b_zero, div_ovf;
    always_comb begin
        prod    = {hi_q, lo_q};
        prod_s  = (a_neg ^ b_neg) ? -prod : prod;
        quo     = (a_neg ^ b_neg) ? -lo_q : lo_q;
        rem     = a_neg ? -hi_q : hi_q;
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        sh      = b_q[SHW-1:0];
        b_zero  = (b_q == {WIDTH{1'b0}});
        div_ovf = i_q && (a_q == MIN_VAL) && (b_q == {WIDTH{1'b1}});
        res_d   = {WIDTH{1'b0}};
        ovf_d   = 1'b0;
        case (af_q)
            AF_AND:  res_d = a_q & b_q;
            AF_OR:   res_d = a_q | b_q;
            AF_ADD: begin
                res_d = sum;
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            AF_SUB: begin
                res_d = diff;
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            AF_XOR:  res_d = a_q ^ b_q;
            AF_NOR:  res_d = ~(a_q | b_q);
            AF_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            AF_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            AF_SLL:  res_d = a_q << sh;
            AF_SRL:  res_d = a_q >> sh;
            AF_SRA:  res_d = WIDTH'($signed(a_q) >>> sh);
            AF_MUL: begin
                res_d = prod_s[WIDTH-1:0];
                ovf_d = i_q ? (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}})
                            : (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            end
            AF_MULH: res_d = prod_s[2*WIDTH-1:WIDTH];
            AF_DIV: begin
                res_d = b_zero ? {WIDTH{1'b1}} : quo;
                ovf_d = b_zero || div_ovf;
            end
            AF_REM: begin
                res_d = b_zero ? a_q : rem;
                ovf_d = b_zero || div_ovf;
            end
            default: begin
                res_d = {WIDTH{1'b0}};
                ovf_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            af_q    <= '0;
            i_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= SrcA;
                        b_q     <= SrcB;
                        af_q    <= af;
                        i_q     <= i;
                        hi_q    <= '0;
                        lo_q    <= in_div ? in_a_mag : in_b_mag;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= in_multi ? S_RUN : S_FIN;
                    end
                end
                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    res_q   <= res_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Alures = res_q;
    assign Zero   = (res_q == {WIDTH{1'b0}});
    assign Neg    = res_q[WIDTH-1];
    assign ovfalu = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit instance driven from a vector table plus handshake/reset sequences, and an 8-bit instance.
module tb_alu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, i;
    logic [31:0] a, b;
    logic [3:0]  af;
    logic        busy, done, zero, neg, ovf;
    logic [31:0] res;

    logic        start8, i8;
    logic [7:0]  a8, b8;
    logic [3:0]  af8;
    logic        busy8, done8, zero8, neg8, ovf8;
    logic [7:0]  res8;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start), .i(i), .SrcA(a), .SrcB(b), .af(af),
        .busy(busy), .done(done), .Alures(res), .Zero(zero), .Neg(neg), .ovfalu(ovf)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .i(i8), .SrcA(a8), .SrcB(b8), .af(af8),
        .busy(busy8), .done(done8), .Alures(res8), .Zero(zero8), .Neg(neg8), .ovfalu(ovf8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit is_multi(input logic [3:0] f);
        return (f == 4'b1010) || (f == 4'b1011) || (f == 4'b1100) || (f == 4'b1101);
    endfunction

    task automatic op32(input logic [3:0] f, input logic si, input logic [31:0] sa, input logic [31:0] sb,
                        input logic [31:0] er, input logic eo, input string nm);
        int  n;
        bit  seen;
        @(negedge clk);
        af = f; i = si; a = sa; b = sb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; af = ~f; i = ~si; a = ~sa; b = ~sb;
        chk($sformatf("%s busy", nm), busy, 1);
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
        end
        chk($sformatf("%s latency", nm), n, is_multi(f) ? 33 : 1);
        chk($sformatf("%s Alures", nm), res, er);
        chk($sformatf("%s Zero", nm), zero, (er == 32'd0));
        chk($sformatf("%s Neg", nm), neg, er[31]);
        chk($sformatf("%s ovfalu", nm), ovf, eo);
        chk($sformatf("%s busy at done", nm), busy, 0);
    endtask

    task automatic op8(input logic [3:0] f, input logic si, input logic [7:0] sa, input logic [7:0] sb,
                       input logic [7:0] er, input logic eo, input string nm);
        int  n;
        bit  seen;
        @(negedge clk);
        af8 = f; i8 = si; a8 = sa; b8 = sb; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~sa; b8 = ~sb;
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (done8) seen = 1;
        end
        chk($sformatf("%s latency", nm), n, is_multi(f) ? 9 : 1);
        chk($sformatf("%s Alures", nm), res8, er);
        chk($sformatf("%s Neg", nm), neg8, er[7]);
        chk($sformatf("%s ovfalu", nm), ovf8, eo);
    endtask

    typedef struct {
        logic [3:0]  f;
        logic        si;
        logic [31:0] sa;
        logic [31:0] sb;
        logic [31:0] er;
        logic        eo;
    } vec_t;

    localparam int NV = 34;
    vec_t tv [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, first;

        tv[0]  = '{4'b0010, 1'b0, 32'd3,          32'd4,          32'd7,          1'b0};
        tv[1]  = '{4'b0011, 1'b0, 32'd3,          32'd4,          32'hFFFFFFFF,   1'b0};
        tv[2]  = '{4'b0110, 1'b0, 32'd3,          32'd4,          32'd1,          1'b0};
        tv[3]  = '{4'b0010, 1'b0, 32'h7FFFFFFF,   32'd1,          32'h80000000,   1'b1};
        tv[4]  = '{4'b1110, 1'b0, 32'h80000000,   32'h21,         32'hC0000000,   1'b0};
        tv[5]  = '{4'b1010, 1'b0, 32'h10000,      32'h10000,      32'd0,          1'b1};
        tv[6]  = '{4'b1011, 1'b0, 32'h10000,      32'h10000,      32'd1,          1'b0};
        tv[7]  = '{4'b1010, 1'b1, 32'hFFFFFFFD,   32'd7,          32'hFFFFFFEB,   1'b0};
        tv[8]  = '{4'b1100, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0};
        tv[9]  = '{4'b1101, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0};
        tv[10] = '{4'b1100, 1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1};
        tv[11] = '{4'b1100, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1};
        tv[12] = '{4'b1101, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b1};
        tv[13] = '{4'b1101, 1'b0, 32'd5,          32'd0,          32'd5,          1'b1};
        tv[14] = '{4'b0000, 1'b0, 32'hF0F0,       32'hFF00,       32'hF000,       1'b0};
        tv[15] = '{4'b0001, 1'b0, 32'hF0F0,       32'hFF00,       32'hFFF0,       1'b0};
        tv[16] = '{4'b0100, 1'b0, 32'hF0F0,       32'hFF00,       32'h0FF0,       1'b0};
        tv[17] = '{4'b0101, 1'b0, 32'd0,          32'd0,          32'hFFFFFFFF,   1'b0};
        tv[18] = '{4'b0111, 1'b0, 32'd1,          32'hFFFFFFFF,   32'd1,          1'b0};
        tv[19] = '{4'b0110, 1'b0, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        tv[20] = '{4'b1000, 1'b0, 32'd1,          32'h1F,         32'h80000000,   1'b0};
        tv[21] = '{4'b1001, 1'b0, 32'h80000000,   32'h3F,         32'd1,          1'b0};
        tv[22] = '{4'b0011, 1'b0, 32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b1};
        tv[23] = '{4'b1111, 1'b0, 32'h12345678,   32'h9ABCDEF0,   32'd0,          1'b0};
        tv[24] = '{4'b1100, 1'b0, 32'd100,        32'd7,          32'd14,         1'b0};
        tv[25] = '{4'b1101, 1'b0, 32'd100,        32'd7,          32'd2,          1'b0};
        tv[26] = '{4'b1011, 1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b0};
        tv[27] = '{4'b1011, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   1'b0};
        tv[28] = '{4'b1010, 1'b1, 32'h80000000,   32'd2,          32'd0,          1'b1};
        tv[29] = '{4'b1100, 1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0};
        tv[30] = '{4'b1101, 1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          1'b0};
        tv[31] = '{4'b1101, 1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1'b1};
        tv[32] = '{4'b1100, 1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   1'b1};
        tv[33] = '{4'b1010, 1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0};

        reset = 1'b1; start = 1'b0; i = 1'b0; a = '0; b = '0; af = '0;
        start8 = 1'b0; i8 = 1'b0; a8 = '0; b8 = '0; af8 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset Alures", res, 0);
        chk("reset Zero", zero, 1);
        chk("reset Neg", neg, 0);
        chk("reset ovfalu", ovf, 0);
        chk("reset8 Zero", zero8, 1);

        for (int k = 0; k < NV; k++)
            op32(tv[k].f, tv[k].si, tv[k].sa, tv[k].sb, tv[k].er, tv[k].eo, $sformatf("vec%0d", k));

        // start held high through a DIV: one done, then a new op taken on the done cycle
        @(negedge clk);
        af = 4'b1100; i = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        ndone = 0; first = -1;
        for (int e = 1; e <= 60 && first < 0; e++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                first = e;
            end
        end
        chk("held start done edge", first, 33);
        chk("held start done count", ndone, 1);
        chk("held start DIV result", res, 14);
        af = 4'b0010; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        chk("back-to-back busy", busy, 1);
        chk("back-to-back no done", done, 0);
        @(posedge clk); #1;
        chk("back-to-back done", done, 1);
        chk("back-to-back Alures", res, 11);
        @(posedge clk); #1;
        chk("done single pulse", done, 0);

        // reset during RUN iteration 10 aborts without a done pulse
        @(negedge clk);
        af = 4'b1010; i = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort Alures", res, 0);
        chk("abort Zero", zero, 1);
        chk("abort ovfalu", ovf, 0);
        ndone = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort no done", ndone, 0);
        op32(4'b0010, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, "post-abort ADD");

        op8(4'b1010, 1'b0, 8'd15,  8'd17,  8'hFF, 1'b0, "w8 MUL");
        op8(4'b1000, 1'b0, 8'd1,   8'h0B,  8'd8,  1'b0, "w8 SLL");
        op8(4'b0010, 1'b0, 8'h7F,  8'd1,   8'h80, 1'b1, "w8 ADD ovf");
        op8(4'b1100, 1'b1, 8'h80,  8'hFF,  8'h80, 1'b1, "w8 DIV min");
        op8(4'b1011, 1'b0, 8'hFF,  8'hFF,  8'hFE, 1'b0, "w8 MULH");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
